hwpf_stride_sched: RTL and testbench

- Shares one HPDcache request/response port between NUM_ENGINES stride prefetch engines.
- Each engine issues CMO prefetch requests through its own valid/ready port. The block arbitrates round-robin, registers the winner in a one-entry output buffer, and tags the TID with the engine index.
- Responses are demultiplexed back to the owning engine by TID.
- Sits between the prefetcher engine array and the dcache requester port.

---
 rtl/hwpf_stride_pkg.sv | 29 ++
 rtl/hwpf_stride_rr_arb.sv | 33 +++
 rtl/hwpf_stride_sched.sv | 166 ++++++++++++++++
 tb/tb_hwpf_stride_sched.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hwpf_stride_pkg.sv
// Shared types for the stride prefetcher and its dcache request scheduler.
// Carries the HPDcache request/response bundles and the engine index type.
package hwpf_stride_pkg;

  localparam int unsigned HWPF_STRIDE_SCHED_MAX_ENGINES = 8;

  typedef logic [$clog2(HWPF_STRIDE_SCHED_MAX_ENGINES)-1:0]
    hwpf_stride_engine_idx_t;

  typedef logic [5:0] hpdcache_tid_t;
  typedef logic [2:0] hpdcache_sid_t;

  typedef struct packed {
    logic [31:0]   addr;
    logic [3:0]    op;
    logic [2:0]    size;
    hpdcache_sid_t sid;
    hpdcache_tid_t tid;
    logic          need_rsp;
  } hpdcache_req_t;

  typedef struct packed {
    logic [31:0]   rdata;
    hpdcache_sid_t sid;
    hpdcache_tid_t tid;
    logic          error;
  } hpdcache_rsp_t;

endpackage

// File: rtl/hwpf_stride_rr_arb.sv
// Round-robin arbiter: first requester at or after ptr_i, modulo N.
// Produces a one-hot grant plus the encoded winner index.
module hwpf_stride_rr_arb
  import hwpf_stride_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]            req_i,
  input  logic [IW-1:0]           ptr_i,
  output logic [N-1:0]            gnt_o,
  output hwpf_stride_engine_idx_t idx_o,
  output logic                    any_o
);

  int unsigned pos;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    pos   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = (32'(ptr_i) + k) % N;
      if (!any_o && req_i[pos[IW-1:0]]) begin
        any_o                 = 1'b1;
        gnt_o[pos[IW-1:0]]    = 1'b1;
        idx_o = hwpf_stride_engine_idx_t'(pos);
      end
    end
  end

endmodule

// File: rtl/hwpf_stride_sched.sv
// Shares one HPDcache port among stride prefetch engines; TID carries engine index.
// HWPF_STRIDE_SCHED_STATS_EN adds grant_cnt_o / stall_cnt_o statistics.
module hwpf_stride_sched
  import hwpf_stride_pkg::*;
#(
  parameter int unsigned NUM_ENGINES        = 4,
  parameter int unsigned INFLIGHT_CNT_WIDTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_ENGINES-1:0]       engine_req_valid_i,
  output logic [NUM_ENGINES-1:0]       engine_req_ready_o,
  input  hpdcache_req_t [NUM_ENGINES-1:0] engine_req_i,
  output logic [NUM_ENGINES-1:0]       engine_rsp_valid_o,
  output hpdcache_rsp_t                engine_rsp_o,
  output logic                         dcache_req_valid_o,
  input  logic                         dcache_req_ready_i,
  output hpdcache_req_t                dcache_req_o,
  input  logic                         dcache_rsp_valid_i,
  input  hpdcache_rsp_t                dcache_rsp_i,
  output logic [NUM_ENGINES-1:0][INFLIGHT_CNT_WIDTH-1:0] inflight_o,
  output logic                         busy_o,
  output logic                         tid_err_o
`ifdef HWPF_STRIDE_SCHED_STATS_EN
  ,
  output logic [NUM_ENGINES-1:0][31:0] grant_cnt_o,
  output logic [31:0]                  stall_cnt_o
`endif
);

  localparam int unsigned IW = $clog2(NUM_ENGINES);

  typedef logic [IW-1:0] idx_t;
  typedef logic [INFLIGHT_CNT_WIDTH-1:0] cnt_t;

  localparam idx_t LAST = idx_t'(NUM_ENGINES - 1);

  logic                    out_valid_q;
  hpdcache_req_t           out_q;
  idx_t                    rr_q;
  cnt_t [NUM_ENGINES-1:0]  cnt_q;
  logic                    tid_err_q;

  logic [NUM_ENGINES-1:0]  arb_gnt;
  hwpf_stride_engine_idx_t arb_idx;
  logic                    arb_any;
  idx_t                    win;
  logic                    buf_free;
  logic                    grant;
  logic                    hs;
  hpdcache_req_t           load_req;
  idx_t                    rsp_idx;
  logic                    rsp_in_range;
  logic [NUM_ENGINES-1:0]  cnt_inc;
  logic [NUM_ENGINES-1:0]  cnt_dec;

  hwpf_stride_rr_arb #(
    .N (NUM_ENGINES)
  ) u_arb (
    .req_i (engine_req_valid_i),
    .ptr_i (rr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign win      = arb_idx[IW-1:0];
  assign buf_free = !out_valid_q || dcache_req_ready_i;
  assign grant    = buf_free && arb_any;
  assign hs       = out_valid_q && dcache_req_ready_i;

  assign engine_req_ready_o = grant ? arb_gnt : '0;

  always_comb begin
    load_req              = engine_req_i[win];
    load_req.tid          = '0;
    load_req.tid[IW-1:0]  = win;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      rr_q        <= '0;
    end else if (grant) begin
      out_valid_q <= 1'b1;
      out_q       <= load_req;
      rr_q        <= (win == LAST) ? '0 : win + idx_t'(1);
    end else if (hs) begin
      out_valid_q <= 1'b0;
    end
  end

  assign dcache_req_valid_o = out_valid_q;
  assign dcache_req_o       = out_q;

  assign rsp_idx      = dcache_rsp_i.tid[IW-1:0];
  assign rsp_in_range = 32'(rsp_idx) < NUM_ENGINES;
  assign engine_rsp_o = dcache_rsp_i;

  always_comb begin
    engine_rsp_valid_o = '0;
    if (dcache_rsp_valid_i && rsp_in_range) begin
      engine_rsp_valid_o[rsp_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tid_err_q <= 1'b0;
    end else if (dcache_rsp_valid_i && !rsp_in_range) begin
      tid_err_q <= 1'b1;
    end
  end

  always_comb begin
    cnt_inc = '0;
    for (int e = 0; e < NUM_ENGINES; e++) begin
      cnt_inc[e] = hs && (out_q.tid[IW-1:0] == idx_t'(e));
    end
  end

  assign cnt_dec = engine_rsp_valid_o;

  // saturating in both directions; inc+dec together cancels
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      for (int e = 0; e < NUM_ENGINES; e++) begin
        if (cnt_inc[e] && !cnt_dec[e] && cnt_q[e] != '1) begin
          cnt_q[e] <= cnt_q[e] + cnt_t'(1);
        end else if (cnt_dec[e] && !cnt_inc[e] && cnt_q[e] != '0) begin
          cnt_q[e] <= cnt_q[e] - cnt_t'(1);
        end
      end
    end
  end

  assign inflight_o = cnt_q;
  assign busy_o     = out_valid_q || (|cnt_q);
  assign tid_err_o  = tid_err_q;

`ifdef HWPF_STRIDE_SCHED_STATS_EN
  logic [NUM_ENGINES-1:0][31:0] grant_cnt_q;
  logic [31:0]                  stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (grant) begin
        grant_cnt_q[win] <= grant_cnt_q[win] + 32'd1;
      end
      if (out_valid_q && !dcache_req_ready_i) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign grant_cnt_o = grant_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hwpf_stride_sched.sv
// Self-checking bench for hwpf_stride_sched: reference model plus directed pins.
// A 3-engine instance covers the out-of-range TID path.
module tb_hwpf_stride_sched;
  import hwpf_stride_pkg::*;

  localparam int N   = 4;
  localparam int CW  = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]          req_valid;
  logic [N-1:0]          req_ready;
  hpdcache_req_t [N-1:0] eng_req;
  logic [N-1:0]          rsp_valid_o;
  hpdcache_rsp_t         eng_rsp;
  logic                  d_valid;
  logic                  d_ready;
  hpdcache_req_t         d_req;
  logic                  d_rsp_valid;
  hpdcache_rsp_t         d_rsp;
  logic [N-1:0][CW-1:0]  inflight;
  logic                  busy;
  logic                  tid_err;

  logic [2:0]            b_ready;
  hpdcache_req_t [2:0]   b_req;
  logic [2:0]            b_rsp_valid;
  hpdcache_rsp_t         b_rsp_o;
  logic                  b_dvalid;
  hpdcache_req_t         b_dreq;
  logic                  b_rsp_in_valid;
  hpdcache_rsp_t         b_rsp;
  logic [2:0][CW-1:0]    b_inflight;
  logic                  b_busy;
  logic                  b_err;

`ifdef HWPF_STRIDE_SCHED_STATS_EN
  logic [N-1:0][31:0]    gcnt;
  logic [31:0]           scnt;
  logic [2:0][31:0]      b_gcnt;
  logic [31:0]           b_scnt;
`endif

  hwpf_stride_sched #(
    .NUM_ENGINES        (N),
    .INFLIGHT_CNT_WIDTH (CW)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .engine_req_valid_i (req_valid),
    .engine_req_ready_o (req_ready),
    .engine_req_i       (eng_req),
    .engine_rsp_valid_o (rsp_valid_o),
    .engine_rsp_o       (eng_rsp),
    .dcache_req_valid_o (d_valid),
    .dcache_req_ready_i (d_ready),
    .dcache_req_o       (d_req),
    .dcache_rsp_valid_i (d_rsp_valid),
    .dcache_rsp_i       (d_rsp),
    .inflight_o         (inflight),
    .busy_o             (busy),
    .tid_err_o          (tid_err)
`ifdef HWPF_STRIDE_SCHED_STATS_EN
    ,
    .grant_cnt_o        (gcnt),
    .stall_cnt_o        (scnt)
`endif
  );

  hwpf_stride_sched #(
    .NUM_ENGINES        (3),
    .INFLIGHT_CNT_WIDTH (CW)
  ) dut3 (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .engine_req_valid_i (3'b000),
    .engine_req_ready_o (b_ready),
    .engine_req_i       (b_req),
    .engine_rsp_valid_o (b_rsp_valid),
    .engine_rsp_o       (b_rsp_o),
    .dcache_req_valid_o (b_dvalid),
    .dcache_req_ready_i (1'b1),
    .dcache_req_o       (b_dreq),
    .dcache_rsp_valid_i (b_rsp_in_valid),
    .dcache_rsp_i       (b_rsp),
    .inflight_o         (b_inflight),
    .busy_o             (b_busy),
    .tid_err_o          (b_err)
`ifdef HWPF_STRIDE_SCHED_STATS_EN
    ,
    .grant_cnt_o        (b_gcnt),
    .stall_cnt_o        (b_scnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic hpdcache_req_t rnd_req();
    hpdcache_req_t r;
    r.addr     = $urandom;
    r.op       = 4'($urandom);
    r.size     = 3'($urandom);
    r.sid      = 3'($urandom);
    r.tid      = 6'($urandom);
    r.need_rsp = 1'($urandom);
    return r;
  endfunction

  function automatic hpdcache_rsp_t rnd_rsp();
    hpdcache_rsp_t r;
    r.rdata = $urandom;
    r.sid   = 3'($urandom);
    r.tid   = 6'($urandom);
    r.error = 1'($urandom);
    return r;
  endfunction

  // first valid engine starting from the round-robin position, else -1
  function automatic int pick(logic [N-1:0] v, int rr);
    for (int k = 0; k < N; k++) begin
      if (v[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  function automatic int clamp(int v);
    return (v < 0) ? 0 : ((v > MAXC) ? MAXC : v);
  endfunction

  // reference model state
  logic          m_valid;
  hpdcache_req_t m_req;
  int            m_rr;
  int            m_cnt [N];
  int unsigned   m_gcnt [N];
  int unsigned   m_stall;

  logic          exp_free;
  logic          exp_hs;
  int            exp_w;
  int            exp_ri;
  logic [N-1:0]  exp_ready;
  logic [N-1:0]  exp_rsp_v;
  hpdcache_req_t exp_load;
  logic          exp_busy;

  always_comb begin
    exp_free  = !m_valid || d_ready;
    exp_hs    = m_valid && d_ready;
    exp_w     = pick(req_valid, m_rr);
    exp_ready = '0;
    exp_load  = '0;
    if (exp_w >= 0) begin
      if (exp_free) exp_ready[exp_w] = 1'b1;
      exp_load     = eng_req[exp_w];
      exp_load.tid = hpdcache_tid_t'(exp_w);
    end
    exp_ri    = int'(d_rsp.tid) % N;
    exp_rsp_v = '0;
    if (d_rsp_valid) exp_rsp_v[exp_ri] = 1'b1;
    exp_busy  = m_valid;
    for (int e = 0; e < N; e++) begin
      if (m_cnt[e] != 0) exp_busy = 1'b1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_req   <= '0;
      m_rr    <= 0;
      m_stall <= 0;
      for (int e = 0; e < N; e++) begin
        m_cnt[e]  <= 0;
        m_gcnt[e] <= 0;
      end
    end else begin
      for (int e = 0; e < N; e++) begin
        m_cnt[e] <= clamp(m_cnt[e]
                  + ((exp_hs && (int'(m_req.tid) % N == e)) ? 1 : 0)
                  - (exp_rsp_v[e] ? 1 : 0));
      end
      if (exp_free && exp_w >= 0) begin
        m_valid        <= 1'b1;
        m_req          <= exp_load;
        m_rr           <= (exp_w + 1) % N;
        m_gcnt[exp_w]  <= m_gcnt[exp_w] + 1;
      end else if (exp_hs) begin
        m_valid <= 1'b0;
      end
      if (m_valid && !d_ready) m_stall <= m_stall + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("req_ready", req_ready, exp_ready);
      chk("dc_valid", d_valid, m_valid);
      chk("dc_req", d_req, m_req);
      chk("rsp_valid", rsp_valid_o, exp_rsp_v);
      chk("rsp_data", eng_rsp, d_rsp);
      for (int e = 0; e < N; e++) begin
        chk("inflight", inflight[e], m_cnt[e]);
      end
      chk("busy", busy, exp_busy);
      chk("tid_err", tid_err, 1'b0);
`ifdef HWPF_STRIDE_SCHED_STATS_EN
      for (int e = 0; e < N; e++) begin
        chk("grant_cnt", gcnt[e], m_gcnt[e]);
      end
      chk("stall_cnt", scnt, m_stall);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_n          = 1'b0;
    req_valid      = '0;
    d_ready        = 1'b0;
    d_rsp_valid    = 1'b0;
    d_rsp          = '0;
    eng_req        = '0;
    b_rsp_in_valid = 1'b0;
    b_rsp          = '0;
    tick();
    rst_n = 1'b1;
  endtask

  hpdcache_req_t sav;

  initial begin
    b_req = '0;
    do_reset();

    // reset state
    @(negedge clk);
    chk("rst_dvalid", d_valid, 1'b0);
    chk("rst_dreq", d_req, 64'd0);
    chk("rst_inflight", inflight, 64'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tiderr", tid_err, 1'b0);
    chk("rst_rspv", rsp_valid_o, 4'b0000);
    tick();

    // all engines valid: strict rotation, one per cycle
    for (int i = 0; i < N; i++) eng_req[i] = rnd_req();
    req_valid = 4'hF;
    d_ready   = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr_gnt", req_ready, 4'b0001 << (k % 4));
      if (k > 0) begin
        chk("rr_tid", d_req.tid, (k - 1) % 4);
        chk("rr_val", d_valid, 1'b1);
      end
      tick();
    end

    // engine 2 stalled behind a blocked dcache
    do_reset();
    eng_req[2] = rnd_req();
    sav        = eng_req[2];
    sav.tid    = 6'd2;
    req_valid  = 4'b0100;
    d_ready    = 1'b0;
    @(negedge clk);
    chk("stall_gnt0", req_ready, 4'b0100);
    tick();
    for (int k = 0; k < 5; k++) begin
      eng_req[2] = rnd_req();
      @(negedge clk);
      chk("stall_hold", d_req, sav);
      chk("stall_rdy", req_ready, 4'b0000);
      chk("stall_val", d_valid, 1'b1);
      tick();
    end
    req_valid = '0;
    d_ready   = 1'b1;
    tick();
    @(negedge clk);
    chk("stall_done", d_valid, 1'b0);
    chk("stall_cnt2", inflight[2], 4'd1);
    tick();

    // engine 1: count 3, then handshake+response, then response alone
    do_reset();
    eng_req[1] = rnd_req();
    req_valid  = 4'b0010;
    d_ready    = 1'b1;
    repeat (4) tick();
    req_valid   = '0;
    d_rsp       = rnd_rsp();
    d_rsp.tid   = 6'd1;
    d_rsp_valid = 1'b1;
    @(negedge clk);
    chk("cnt_pre", inflight[1], 4'd3);
    chk("rsp_route", rsp_valid_o, 4'b0010);
    tick();
    @(negedge clk);
    chk("cnt_both", inflight[1], 4'd3);
    tick();
    d_rsp_valid = 1'b0;
    @(negedge clk);
    chk("cnt_dec", inflight[1], 4'd2);
    tick();

    // saturation, then asynchronous reset mid-burst
    do_reset();
    eng_req[0] = rnd_req();
    req_valid  = 4'b0001;
    d_ready    = 1'b1;
    repeat (17) tick();
    @(negedge clk);
    chk("sat", inflight[0], 4'd15);
    chk("sat_busy", busy, 1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_dvalid", d_valid, 1'b0);
    chk("arst_dreq", d_req, 64'd0);
    chk("arst_inflight", inflight, 64'd0);
    chk("arst_busy", busy, 1'b0);
    tick();
    rst_n       = 1'b1;
    req_valid   = '0;
    d_rsp       = rnd_rsp();
    d_rsp.tid   = 6'd0;
    d_rsp_valid = 1'b1;
    @(negedge clk);
    chk("post_rst_rsp", rsp_valid_o, 4'b0001);
    tick();
    d_rsp_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_cnt", inflight[0], 4'd0);
    tick();

    // three-engine instance: TID range check is sticky
    do_reset();
    b_rsp          = rnd_rsp();
    b_rsp.tid      = 6'd1;
    b_rsp_in_valid = 1'b1;
    #1;
    chk("n3_rsp1", b_rsp_valid, 3'b010);
    chk("n3_err0", b_err, 1'b0);
    b_rsp.tid = 6'd3;
    #1;
    chk("n3_rsp3", b_rsp_valid, 3'b000);
    chk("n3_bcast", b_rsp_o, b_rsp);
    tick();
    b_rsp.tid = 6'd2;
    #1;
    chk("n3_err1", b_err, 1'b1);
    chk("n3_rsp2", b_rsp_valid, 3'b100);
    tick();
    b_rsp_in_valid = 1'b0;
    repeat (2) tick();
    chk("n3_sticky", b_err, 1'b1);

`ifdef HWPF_STRIDE_SCHED_STATS_EN
    do_reset();
    eng_req[3] = rnd_req();
    req_valid  = 4'b1000;
    d_ready    = 1'b1;
    repeat (10) tick();
    req_valid = '0;
    d_ready   = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("stat_gcnt3", gcnt[3], 32'd10);
    chk("stat_stall", scnt, 32'd4);
    tick();
`endif

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      req_valid   = 4'($urandom);
      d_ready     = ($urandom_range(0, 3) != 0);
      d_rsp_valid = 1'($urandom);
      d_rsp       = rnd_rsp();
      for (int i = 0; i < N; i++) eng_req[i] = rnd_req();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
